// File: rtl/poly1305_pkg.sv
// Shared types and the Poly1305 padding rule used by the message packer.
package poly1305_pkg;

    localparam int         BLOCK_BYTES = 16;
    localparam logic [7:0] PAD_BYTE    = 8'h01;

    typedef enum logic [1:0] {FILL, LOAD, WAIT} packer_state_t;

    // Keep bytes below len, put PAD_BYTE at len (when len < 16), zero everything above.
    function automatic logic [127:0] block_pad(input logic [127:0] data, input logic [4:0] len);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (k < int'(len))
                r[8*k +: 8] = data[8*k +: 8];
            else if (k == int'(len))
                r[8*k +: 8] = PAD_BYTE;
        end
        return r;
    endfunction

endpackage

// File: rtl/poly1305_block_pad.sv
// Combinational pad/mask of an assembled 16-byte block holding len valid bytes.
module poly1305_block_pad
    import poly1305_pkg::*;
(
    input  logic [127:0] blk_in,
    input  logic [4:0]   len,
    output logic [127:0] blk_out
);

    assign blk_out = block_pad(blk_in, len);

endmodule

// File: rtl/poly1305_msg_packer.sv
// Packs a little-endian word stream into padded 16-byte Poly1305 blocks and sequences the core.
// Optional byte-length output msg_len when POLY1305_PACK_LEN_EN is defined.
module poly1305_msg_packer
    import poly1305_pkg::*;
#(
    parameter int BPW   = 4,
    parameter int LEN_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic [8*BPW-1:0]     in_data,
    input  logic [$clog2(BPW):0] in_bytes,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [127:0]         m,
    output logic                 fb,
    output logic                 first,
    output logic                 ld,
    input  logic                 rdy,
    output logic                 tag_valid,
    output logic                 busy
`ifdef POLY1305_PACK_LEN_EN
    ,
    output logic [LEN_W-1:0]     msg_len
`endif
);

    localparam int WPB    = BLOCK_BYTES / BPW;
    localparam int WIDX_W = (WPB > 1) ? $clog2(WPB) : 1;

    if (!(BPW == 1 || BPW == 2 || BPW == 4 || BPW == 8 || BPW == 16) || LEN_W < 1) begin : g_bad_cfg
        $error("poly1305_msg_packer: illegal BPW/LEN_W");
    end

    packer_state_t      state_q, state_d;
    logic [WIDX_W-1:0]  widx;
    logic               last_seen;
    logic               accept;
    logic               blk_full;
    logic [4:0]         nb;
    logic [4:0]         blk_len;
    logic [127:0]       blk_asm;
    logic [127:0]       blk_pad_out;

    // A byte count of 0 on the final word means a full word.
    assign nb       = (in_bytes == '0) ? 5'(BPW) : 5'(in_bytes);
    assign blk_len  = 5'(int'(widx) * BPW) + nb;
    assign blk_full = (widx == WIDX_W'(WPB - 1));
    assign accept   = in_valid && in_ready;

    always_comb begin
        blk_asm = m;
        for (int w = 0; w < WPB; w++) begin
            if (widx == WIDX_W'(w))
                blk_asm[w*BPW*8 +: BPW*8] = in_data;
        end
    end

    poly1305_block_pad u_pad (
        .blk_in  (blk_asm),
        .len     (blk_len),
        .blk_out (blk_pad_out)
    );

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) state_q <= FILL;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        ld       = 1'b0;
        unique case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || blk_full)) state_d = LOAD;
            end
            LOAD: begin
                ld      = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (rdy) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m         <= '0;
            fb        <= 1'b0;
            first     <= 1'b1;
            tag_valid <= 1'b0;
            busy      <= 1'b0;
            widx      <= '0;
            last_seen <= 1'b0;
        end else begin
            tag_valid <= 1'b0;
            if (accept) begin
                busy <= 1'b1;
                if (in_last) begin
                    m         <= blk_pad_out;
                    fb        <= (blk_len == 5'd16);
                    last_seen <= 1'b1;
                end else begin
                    m <= blk_asm;
                    if (blk_full) fb   <= 1'b1;
                    else          widx <= widx + 1'b1;
                end
            end
            // m/fb/first stay frozen through WAIT; the core may read them any time before rdy.
            if (state_q == WAIT && rdy) begin
                first <= 1'b0;
                m     <= '0;
                fb    <= 1'b0;
                widx  <= '0;
                if (last_seen) begin
                    tag_valid <= 1'b1;
                    first     <= 1'b1;
                    busy      <= 1'b0;
                    last_seen <= 1'b0;
                end
            end
        end
    end

`ifdef POLY1305_PACK_LEN_EN
    logic [LEN_W-1:0] len_base;
    logic [LEN_W:0]   len_sum;

    // The count is presented during tag_valid and restarts from zero right after it.
    always_comb begin
        len_base = tag_valid ? '0 : msg_len;
        len_sum  = {1'b0, len_base} + (LEN_W+1)'(in_last ? nb : 5'(BPW));
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)     msg_len <= '0;
        else if (accept) msg_len <= len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
        else             msg_len <= len_base;
    end
`endif

endmodule

// File: tb/tb_poly1305_msg_packer.sv
// Scoreboard bench for poly1305_msg_packer (BPW=4): byte-level padding model plus a core responder.
module tb_poly1305_msg_packer;

    localparam int BPW = 4;

    typedef struct {
        logic [127:0] m;
        logic         fb;
        logic         first;
        logic         last;
        int           len;
    } blk_t;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic [8*BPW-1:0] in_data = '0;
    logic [2:0]     in_bytes = '0;
    logic           in_last = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [127:0]   m;
    logic           fb, first, ld, tag_valid, busy;
    logic           core_rdy = 1'b0;
    logic           stray_rdy = 1'b0;
    logic           rdy;
`ifdef POLY1305_PACK_LEN_EN
    logic [63:0]    msg_len;
`endif

    assign rdy = core_rdy | stray_rdy;

    poly1305_msg_packer #(.BPW(BPW), .LEN_W(64)) dut (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .fb        (fb),
        .first     (first),
        .ld        (ld),
        .rdy       (rdy),
        .tag_valid (tag_valid),
        .busy      (busy)
`ifdef POLY1305_PACK_LEN_EN
        ,
        .msg_len   (msg_len)
`endif
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           tag_cnt = 0;
    int           rdy_dly = 5;
    bit           resp_en = 1'b1;
    bit           abort   = 1'b0;
    bit           sender_done = 1'b0;
    blk_t         exp_q[$];
    logic [127:0] ld_m[$];
    logic [7:0]   msg [0:63];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected blocks straight from the padding rule, one per 16 message bytes.
    task automatic push_msg(input int n);
        blk_t e;
        int   nblk, l;
        nblk = (n + 15) / 16;
        for (int k = 0; k < nblk; k++) begin
            l = (n - 16*k > 16) ? 16 : n - 16*k;
            e.m = '0;
            for (int j = 0; j < 16; j++) begin
                if (j < l)       e.m[8*j +: 8] = msg[16*k + j];
                else if (j == l) e.m[8*j +: 8] = 8'h01;
            end
            e.fb    = (l == 16);
            e.first = (k == 0);
            e.last  = (k == nblk - 1);
            e.len   = n;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_msg(input int n, input bit gaps, input bit zero_nb);
        int nw;
        nw = (n + BPW - 1) / BPW;
        for (int w = 0; w < nw; w++) begin
            int               nb, t;
            logic [8*BPW-1:0] d;
            bit               ok;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    ok = in_ready;
                    @(posedge clk); #1;
                    if (ok && $urandom_range(0, 1) == 1) begin
                        stray_rdy = 1'b1;
                        @(posedge clk); #1;
                        stray_rdy = 1'b0;
                    end
                end
            end
            nb = (n - w*BPW < BPW) ? n - w*BPW : BPW;
            for (int b = 0; b < BPW; b++)
                d[8*b +: 8] = (b < nb) ? msg[w*BPW + b] : 8'hEE;
            in_data  = d;
            in_last  = (w == nw - 1);
            in_bytes = in_last ? ((nb == BPW && zero_nb) ? 3'd0 : 3'(nb)) : 3'($urandom_range(0, 7));
            in_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (in_ready !== 1'b1 && !abort && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (abort || t >= 300) begin
                if (!abort) chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic run_msg(input int n, input bit gaps, input bit zero_nb, input int dly);
        int t0, t;
        t0 = tag_cnt;
        t  = 0;
        rdy_dly = dly;
        push_msg(n);
        send_msg(n, gaps, zero_nb);
        while (tag_cnt == t0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("tag_cnt", tag_cnt, t0 + 1);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_q", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_ld(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (ld !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(tag, ld, 1);
    endtask

    initial begin : tag_mon
        forever begin
            @(negedge clk);
            if (tag_valid === 1'b1) tag_cnt++;
        end
    end

    // Core model: checks each ld against the scoreboard, holds, then returns rdy.
    initial begin : core_model
        blk_t e;
        bit   stable;
        forever begin
            @(negedge clk);
            if (resp_en && ld === 1'b1) begin
                ld_m.push_back(m);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ld", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ld_m", m, e.m);
                    chk("ld_fb", fb, e.fb);
                    chk("ld_first", first, e.first);
                    chk("ld_busy", busy, 1);
                    stable = 1'b1;
                    repeat (rdy_dly) begin
                        @(negedge clk);
                        if (m !== e.m || fb !== e.fb || first !== e.first ||
                            in_ready !== 1'b0 || ld !== 1'b0) stable = 1'b0;
                    end
                    chk("hold_until_rdy", stable, 1);
                    @(posedge clk); #1 core_rdy = 1'b1;
                    @(posedge clk); #1 core_rdy = 1'b0;
                    @(negedge clk);
                    chk("tag_valid", tag_valid, e.last);
`ifdef POLY1305_PACK_LEN_EN
                    if (e.last) begin
                        chk("msg_len", msg_len, e.len);
                        @(negedge clk);
                        chk("msg_len_clr", msg_len, 0);
                    end
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        string s;
        s = "Cryptographic Forum Research Group";

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_m", m, 0);
        chk("rst_fb", fb, 0);
        chk("rst_first", first, 1);
        chk("rst_ld", ld, 0);
        chk("rst_tag_valid", tag_valid, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 rst_ni = 1'b1;

        // RFC 8439 2.5.2 message, 34 bytes
        for (int i = 0; i < s.len(); i++) msg[i] = s[i];
        ld_m.delete();
        run_msg(34, 1'b0, 1'b0, 5);
        chk("rfc_nblk", ld_m.size(), 3);
        chk("rfc_m1", ld_m[0], 128'h6f4620636968706172676f7470797243);
        chk("rfc_m3", ld_m[2], 128'h017075);

        // exactly one block, last word tagged with in_bytes=0 (full word)
        for (int i = 0; i < 16; i++) msg[i] = 8'(8'h10 + i);
        ld_m.delete();
        run_msg(16, 1'b0, 1'b1, 3);
        chk("b16_nblk", ld_m.size(), 1);

        msg[0] = 8'hAB;
        ld_m.delete();
        run_msg(1, 1'b0, 1'b0, 2);
        chk("b1_m", ld_m[0], 128'h01AB);

        // random gaps, stray rdy in FILL, long core latency
        for (int r = 0; r < 4; r++) begin
            int n;
            case (r)
                0:       n = 45;
                1:       n = 48;
                2:       n = 7;
                default: n = 33;
            endcase
            for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
            run_msg(n, 1'b1, r[0], 20);
        end

        // abort mid-WAIT of block 2 with async reset
        for (int i = 0; i < s.len(); i++) msg[i] = s[i];
        resp_en = 1'b0;
        sender_done = 1'b0;
        fork
            begin
                send_msg(34, 1'b0, 1'b0);
                sender_done = 1'b1;
            end
        join_none
        wait_ld("abort_ld1");
        chk("abort_first1", first, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 core_rdy = 1'b1;
        @(posedge clk); #1 core_rdy = 1'b0;
        wait_ld("abort_ld2");
        chk("abort_first2", first, 0);
        @(negedge clk);
        #3;
        abort  = 1'b1;
        rst_ni = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_m", m, 0);
        chk("arst_fb", fb, 0);
        chk("arst_first", first, 1);
        chk("arst_ld", ld, 0);
        chk("arst_tag_valid", tag_valid, 0);
        chk("arst_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("abort_sender", sender_done, 1);
        @(posedge clk); #1;
        rst_ni  = 1'b1;
        abort   = 1'b0;
        resp_en = 1'b1;
        @(posedge clk); #1;

        msg[0] = 8'h5C;
        ld_m.delete();
        run_msg(1, 1'b0, 1'b0, 4);
        chk("post_rst_m", ld_m[0], 128'h015C);
        chk("final_q", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
